// File: rtl/lidar_entropy_pkg.sv
// Shared definitions for the LiDAR entropy decoder front end.
// Holds the default buffer geometry, the bit-feeder state encoding and
// the largest number of bits the range normaliser may drop in one cycle.
package lidar_entropy_pkg;

   localparam int BUF_W_DEF   = 32;
   localparam int WIN_W_DEF   = 16;
   localparam int CNT_W_DEF   = 6;
   localparam int MAX_CONSUME = 16;
   localparam int SHIFT_W     = $clog2(MAX_CONSUME + 1);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } feederState_e;

endpackage

// File: rtl/bit_buffer_shifter.sv
// Combinational datapath of the bit feeder: drops up to MAX_CONSUME bits
// from the MSB end of a left-aligned buffer, then ORs one byte in at a
// variable offset measured from the MSB. The caller guarantees that all
// bits below the fill level are zero, so OR-ing in the byte is a write.
module bit_buffer_shifter
   import lidar_entropy_pkg::*;
#(
   parameter int BUF_W = BUF_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic [BUF_W-1:0]   bufIn_i,
   input  logic [SHIFT_W-1:0] shiftAmt_i,
   input  logic               insertEn_i,
   input  logic [7:0]         byte_i,
   input  logic [CNT_W-1:0]   offset_i,
   output logic [BUF_W-1:0]   bufOut_o
);

   logic [BUF_W-1:0] shifted;
   logic [BUF_W-1:0] inserted;

   // Shift first, then place the new byte just below the surviving bits
   always_comb begin
      shifted  = bufIn_i << shiftAmt_i;
      inserted = '0;
      if (insertEn_i) begin
         inserted = {byte_i, {(BUF_W-8){1'b0}}} >> offset_i;
      end
      bufOut_o = shifted | inserted;
   end

endmodule

// File: rtl/bitstream_window_feeder.sv
// Bit feeder for the LiDAR entropy decoder's range calculator.
// Packs source bytes MSB-first into a left-aligned bit buffer, exposes the
// top WIN_W bits as a lookahead window and drops bits as the normaliser
// consumes them. Optional statistics counters: define BITFEED_STATS_EN.
module bitstream_window_feeder
   import lidar_entropy_pkg::*;
#(
   parameter int BUF_W = BUF_W_DEF,
   parameter int WIN_W = WIN_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   input  logic             stream_end,
   input  logic             consume_en,
   input  logic [4:0]       consume_bits,
   output logic [WIN_W-1:0] bitstream,
   output logic             window_valid,
   output logic [CNT_W-1:0] bits_avail,
   output logic             underrun_flag,
   output logic             done
`ifdef BITFEED_STATS_EN
   ,
   output logic [31:0]      total_bits_consumed,
   output logic [31:0]      bytes_accepted
`endif
);

   logic [BUF_W-1:0] bufData_q, bufData_d, shiftOut;
   logic [CNT_W-1:0] bitsAvail_q, bitsAvail_d;
   logic [CNT_W-1:0] effConsume, shiftAmt, remain;
   feederState_e     state_q, state_d;
   logic             underrun_q, underrun_d;
   logic             readyEn_q;
   logic             underrunNow;
   logic             accept;

   // Work out how many bits really leave the buffer this cycle; an
   // over-sized or over-long consume is an underrun and shifts nothing
   always_comb begin
      effConsume  = consume_en ? CNT_W'(consume_bits) : '0;
      underrunNow = consume_en &&
                    ((consume_bits > 5'(MAX_CONSUME)) || (effConsume > bitsAvail_q));
      shiftAmt    = underrunNow ? '0 : effConsume;
      remain      = bitsAvail_q - shiftAmt;
   end

   assign byte_ready = readyEn_q && (state_q != DRAIN) && !flush &&
                       (remain <= CNT_W'(BUF_W - 8));
   assign accept     = byte_valid && byte_ready;

   bit_buffer_shifter #(
      .BUF_W (BUF_W),
      .CNT_W (CNT_W)
   ) u_shifter (
      .bufIn_i    (bufData_q),
      .shiftAmt_i (shiftAmt[SHIFT_W-1:0]),
      .insertEn_i (accept),
      .byte_i     (byte_data),
      .offset_i   (remain),
      .bufOut_o   (shiftOut)
   );

   // Next buffer contents, fill level, sticky underrun and FSM state;
   // flush overrides everything and restarts from an empty FILL
   always_comb begin
      bufData_d   = shiftOut;
      bitsAvail_d = remain + (accept ? CNT_W'(8) : '0);
      underrun_d  = underrun_q | underrunNow;
      state_d     = state_q;
      case (state_q)
         FILL: begin
            if (stream_end) begin
               state_d = DRAIN;
            end else if (bitsAvail_d >= CNT_W'(WIN_W)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (stream_end) begin
               state_d = DRAIN;
            end else if (bitsAvail_d < CNT_W'(WIN_W)) begin
               state_d = FILL;
            end
         end
         DRAIN:   state_d = DRAIN;
         default: state_d = FILL;
      endcase
      if (flush) begin
         bufData_d   = '0;
         bitsAvail_d = '0;
         underrun_d  = 1'b0;
         state_d     = FILL;
      end
   end

   // State registers; readyEn_q holds off byte_ready until the first edge
   // after reset so the source never sees a handshake during reset release
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bufData_q   <= '0;
         bitsAvail_q <= '0;
         underrun_q  <= 1'b0;
         state_q     <= FILL;
         readyEn_q   <= 1'b0;
      end else begin
         bufData_q   <= bufData_d;
         bitsAvail_q <= bitsAvail_d;
         underrun_q  <= underrun_d;
         state_q     <= state_d;
         readyEn_q   <= 1'b1;
      end
   end

   assign bitstream     = bufData_q[BUF_W-1 -: WIN_W];
   assign window_valid  = (state_q != FILL);
   assign bits_avail    = bitsAvail_q;
   assign underrun_flag = underrun_q;
   assign done          = (state_q == DRAIN) && (bitsAvail_q == '0);

`ifdef BITFEED_STATS_EN
   logic [31:0] totalBits_q;
   logic [31:0] bytesAcc_q;

   // Free-running wrap-around counters of consumed bits and accepted bytes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         totalBits_q <= '0;
         bytesAcc_q  <= '0;
      end else if (flush) begin
         totalBits_q <= '0;
         bytesAcc_q  <= '0;
      end else begin
         totalBits_q <= totalBits_q + 32'(shiftAmt);
         bytesAcc_q  <= bytesAcc_q + (accept ? 32'd1 : 32'd0);
      end
   end

   assign total_bits_consumed = totalBits_q;
   assign bytes_accepted      = bytesAcc_q;
`endif

endmodule

// File: tb/tb_bitstream_window_feeder.sv
// Directed, table-driven bench for bitstream_window_feeder.
module tb_bitstream_window_feeder;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        stream_end;
   logic        consume_en;
   logic [4:0]  consume_bits;
   logic [15:0] bitstream;
   logic        window_valid;
   logic [5:0]  bits_avail;
   logic        underrun_flag;
   logic        done;

   int testsRun  = 0;
   int failCount = 0;

   typedef struct {
      logic        fl;
      logic        bv;
      logic [7:0]  bd;
      logic        ce;
      logic [4:0]  cb;
      logic        se;
      logic        expReady;
      logic [15:0] expBits;
      logic [5:0]  expAvail;
      logic        expValid;
      logic        expUnder;
      logic        expDone;
   } vec_t;

   vec_t vecs[11];
   vec_t v;

   bitstream_window_feeder dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready),
      .stream_end    (stream_end),
      .consume_en    (consume_en),
      .consume_bits  (consume_bits),
      .bitstream     (bitstream),
      .window_valid  (window_valid),
      .bits_avail    (bits_avail),
      .underrun_flag (underrun_flag),
      .done          (done)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after a rising edge, check the
   // combinational ready, then check registered outputs after the edge
   task automatic applyStimulus(input vec_t s, input string tag);
      flush        = s.fl;
      byte_valid   = s.bv;
      byte_data    = s.bd;
      consume_en   = s.ce;
      consume_bits = s.cb;
      stream_end   = s.se;
      #1;
      checkOutput({tag, ".ready"}, 32'(byte_ready), 32'(s.expReady));
      @(posedge clk);
      #1;
      checkOutput({tag, ".bitstream"}, 32'(bitstream), 32'(s.expBits));
      checkOutput({tag, ".avail"}, 32'(bits_avail), 32'(s.expAvail));
      checkOutput({tag, ".valid"}, 32'(window_valid), 32'(s.expValid));
      checkOutput({tag, ".underrun"}, 32'(underrun_flag), 32'(s.expUnder));
      checkOutput({tag, ".done"}, 32'(done), 32'(s.expDone));
   endtask

   initial begin
      // fl  bv    bd     ce   cb    se  rdy  bits      avail v  u  d
      vecs[0]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 5'd0,  1'b0, 1'b1, 16'hA500, 6'd8,  1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 5'd0,  1'b0, 1'b1, 16'hA53C, 6'd16, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 8'hF0, 1'b0, 5'd0,  1'b0, 1'b1, 16'hA53C, 6'd24, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd4,  1'b0, 1'b1, 16'h53CF, 6'd20, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 8'h12, 1'b0, 5'd0,  1'b0, 1'b1, 16'h53CF, 6'd28, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 8'h77, 1'b0, 5'd0,  1'b0, 1'b0, 16'h53CF, 6'd28, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 8'h77, 1'b1, 5'd8,  1'b0, 1'b1, 16'hCF01, 6'd28, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd17, 1'b0, 1'b0, 16'hCF01, 6'd28, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd12, 1'b0, 1'b1, 16'h1277, 6'd16, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1,  1'b0, 1'b1, 16'h24EE, 6'd15, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd16, 1'b0, 1'b1, 16'h24EE, 6'd15, 1'b0, 1'b1, 1'b0};

      reset        = 1'b1;
      flush        = 1'b0;
      byte_valid   = 1'b0;
      byte_data    = 8'h00;
      stream_end   = 1'b0;
      consume_en   = 1'b0;
      consume_bits = 5'd0;

      // Reset state
      #12;
      checkOutput("rst.bitstream", 32'(bitstream), 32'h0);
      checkOutput("rst.avail", 32'(bits_avail), 32'h0);
      checkOutput("rst.valid", 32'(window_valid), 32'h0);
      checkOutput("rst.underrun", 32'(underrun_flag), 32'h0);
      checkOutput("rst.done", 32'(done), 32'h0);
      checkOutput("rst.ready", 32'(byte_ready), 32'h0);
      reset = 1'b0;
      #2;
      checkOutput("rel.readyLow", 32'(byte_ready), 32'h0);
      @(posedge clk);
      #1;
      checkOutput("rel.readyHigh", 32'(byte_ready), 32'h1);

      // Fill, consume, back-pressure and underrun table
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
      end

      // Flush has priority and refuses the offered byte
      v = '{1'b1, 1'b1, 8'hA5, 1'b0, 5'd0, 1'b0, 1'b0, 16'h0000, 6'd0, 1'b0, 1'b0, 1'b0};
      applyStimulus(v, "flushA");

      // Underrun at bits_avail=16, including a byte appended at old level
      v = '{1'b0, 1'b1, 8'hA5, 1'b0, 5'd0, 1'b0, 1'b1, 16'hA500, 6'd8, 1'b0, 1'b0, 1'b0};
      applyStimulus(v, "undA5");
      v = '{1'b0, 1'b1, 8'h3C, 1'b0, 5'd0, 1'b0, 1'b1, 16'hA53C, 6'd16, 1'b1, 1'b0, 1'b0};
      applyStimulus(v, "und3C");
      v = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd17, 1'b0, 1'b1, 16'hA53C, 6'd16, 1'b1, 1'b1, 1'b0};
      applyStimulus(v, "und17");
      v = '{1'b0, 1'b1, 8'h5A, 1'b1, 5'd17, 1'b0, 1'b1, 16'hA53C, 6'd24, 1'b1, 1'b1, 1'b0};
      applyStimulus(v, "undAppend");
      v = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 16'hA53C, 6'd24, 1'b1, 1'b1, 1'b0};
      applyStimulus(v, "undSticky");
      v = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 16'h0000, 6'd0, 1'b0, 1'b0, 1'b0};
      applyStimulus(v, "undFlush");

      // stream_end with 12 bits left, then drain to empty
      v = '{1'b0, 1'b1, 8'hA5, 1'b0, 5'd0, 1'b0, 1'b1, 16'hA500, 6'd8, 1'b0, 1'b0, 1'b0};
      applyStimulus(v, "drnA5");
      v = '{1'b0, 1'b1, 8'h3C, 1'b0, 5'd0, 1'b0, 1'b1, 16'hA53C, 6'd16, 1'b1, 1'b0, 1'b0};
      applyStimulus(v, "drn3C");
      v = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd4, 1'b1, 1'b1, 16'h53C0, 6'd12, 1'b1, 1'b0, 1'b0};
      applyStimulus(v, "drnEnd");
      v = '{1'b0, 1'b1, 8'h99, 1'b1, 5'd12, 1'b0, 1'b0, 16'h0000, 6'd0, 1'b1, 1'b0, 1'b1};
      applyStimulus(v, "drnEmpty");
      v = '{1'b0, 1'b1, 8'h99, 1'b0, 5'd0, 1'b0, 1'b0, 16'h0000, 6'd0, 1'b1, 1'b0, 1'b1};
      applyStimulus(v, "drnHold");
      v = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 16'h0000, 6'd0, 1'b0, 1'b0, 1'b0};
      applyStimulus(v, "drnFlush");

      // stream_end together with a byte handshake keeps the byte
      v = '{1'b0, 1'b1, 8'hC3, 1'b0, 5'd0, 1'b1, 1'b1, 16'hC300, 6'd8, 1'b1, 1'b0, 1'b0};
      applyStimulus(v, "endByte");
      v = '{1'b0, 1'b1, 8'h11, 1'b0, 5'd0, 1'b0, 1'b0, 16'hC300, 6'd8, 1'b1, 1'b0, 1'b0};
      applyStimulus(v, "endHold");
      v = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 16'h0000, 6'd0, 1'b0, 1'b0, 1'b0};
      applyStimulus(v, "endFlush");

      // Asynchronous reset in the middle of RUN with 24 bits held
      v = '{1'b0, 1'b1, 8'hA5, 1'b0, 5'd0, 1'b0, 1'b1, 16'hA500, 6'd8, 1'b0, 1'b0, 1'b0};
      applyStimulus(v, "arA5");
      v = '{1'b0, 1'b1, 8'h3C, 1'b0, 5'd0, 1'b0, 1'b1, 16'hA53C, 6'd16, 1'b1, 1'b0, 1'b0};
      applyStimulus(v, "ar3C");
      v = '{1'b0, 1'b1, 8'hF0, 1'b0, 5'd0, 1'b0, 1'b1, 16'hA53C, 6'd24, 1'b1, 1'b0, 1'b0};
      applyStimulus(v, "arF0");
      byte_valid = 1'b0;
      reset      = 1'b1;
      #1;
      checkOutput("ar.bitstream", 32'(bitstream), 32'h0);
      checkOutput("ar.avail", 32'(bits_avail), 32'h0);
      checkOutput("ar.valid", 32'(window_valid), 32'h0);
      checkOutput("ar.underrun", 32'(underrun_flag), 32'h0);
      checkOutput("ar.done", 32'(done), 32'h0);
      checkOutput("ar.ready", 32'(byte_ready), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("ar.readyLow", 32'(byte_ready), 32'h0);
      @(posedge clk);
      #1;
      checkOutput("ar.readyHigh", 32'(byte_ready), 32'h1);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
